// File: rtl/prc_bus_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : prc_bus_arbiter                                                   |
// | Purpose : Grants the system bus to the PRC at CPU instruction boundaries,   |
// |           stalls the CPU during PRC ownership, muxes bus signals and counts |
// |           stolen cycles.                                                    |
// | Revision: 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
module prc_bus_arbiter #(
  parameter int RELEASE_GAP  = 2,
  parameter int SYNC_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] cpu_address,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [1:0]  cpu_bus_status,
  input  logic        cpu_sync,
  output logic        cpu_wait,
  input  logic        prc_bus_request,
  output logic        prc_bus_ack,
  input  logic [23:0] prc_address,
  input  logic [7:0]  prc_data_out,
  input  logic        prc_read,
  input  logic        prc_write,
  input  logic [1:0]  prc_bus_status,
  output logic [23:0] bus_address,
  output logic [7:0]  bus_data_out,
  output logic        bus_read,
  output logic        bus_write,
  output logic [1:0]  bus_status,
  input  logic        stolen_clear,
  output logic [15:0] stolen_cycles,
  output logic        sync_timeout
);

  localparam int c_gap_w  = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP) : 1;
  localparam int c_wait_w = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [c_gap_w-1:0]  c_gap_load = c_gap_w'(RELEASE_GAP - 1);
  localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(SYNC_TIMEOUT);

  typedef enum logic [1:0] {
    ST_CPU       = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_PRC       = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [c_gap_w-1:0]  r_gap_cnt;
  logic [c_gap_w-1:0]  w_gap_cnt_next;
  logic [c_wait_w-1:0] r_wait_cnt;
  logic                r_granted;
  logic [15:0]         r_stolen;
  logic                r_sync_timeout;
  logic                w_owner_prc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_CPU;
      r_gap_cnt <= '0;
      r_granted <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_gap_cnt <= w_gap_cnt_next;
      r_granted <= (w_next_state == ST_PRC);
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_gap_cnt_next = r_gap_cnt;
    case (r_state)
      ST_CPU: begin
        if (prc_bus_request && (r_gap_cnt == '0)) w_next_state = ST_WAIT_SYNC;
      end
      ST_WAIT_SYNC: begin
        if (!prc_bus_request)
          w_next_state = ST_CPU;
        else if (cpu_sync && !cpu_read && !cpu_write)
          w_next_state = ST_PRC;
      end
      ST_PRC: begin
        if (!prc_bus_request) begin
          w_next_state   = ST_GAP;
          w_gap_cnt_next = c_gap_load;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == '0)
          w_next_state = ST_CPU;
        else
          w_gap_cnt_next = r_gap_cnt - 1'b1;
      end
      default: w_next_state = ST_CPU;
    endcase
  end

  // r_wait_cnt holds completed WAIT_SYNC cycles; the flag fires on the last one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt     <= '0;
      r_sync_timeout <= 1'b0;
    end else if (r_state == ST_WAIT_SYNC) begin
      if (r_wait_cnt != c_wait_max) r_wait_cnt <= r_wait_cnt + 1'b1;
      if (r_wait_cnt == c_wait_max - 1'b1) r_sync_timeout <= 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_stolen <= '0;
    else if (stolen_clear)
      r_stolen <= '0;
    else if ((r_state == ST_PRC) && (r_stolen != 16'hFFFF))
      r_stolen <= r_stolen + 16'd1;
  end

  assign w_owner_prc   = (r_state == ST_PRC);
  assign bus_address   = w_owner_prc ? prc_address    : cpu_address;
  assign bus_data_out  = w_owner_prc ? prc_data_out   : cpu_data_out;
  assign bus_read      = w_owner_prc ? prc_read       : cpu_read;
  assign bus_write     = w_owner_prc ? prc_write      : cpu_write;
  assign bus_status    = w_owner_prc ? prc_bus_status : cpu_bus_status;

  assign cpu_wait      = r_granted;
  assign prc_bus_ack   = r_granted;
  assign stolen_cycles = r_stolen;
  assign sync_timeout  = r_sync_timeout;

endmodule
`default_nettype wire

// File: tb/tb_prc_bus_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_prc_bus_arbiter                                                |
// | Purpose : Directed and randomized bench for prc_bus_arbiter with a         |
// |           behavioural ownership model.                                      |
// | Revision: 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
module tb_prc_bus_arbiter;

  localparam int RELEASE_GAP  = 2;
  localparam int SYNC_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] cpu_address, prc_address, bus_address;
  logic [7:0]  cpu_data_out, prc_data_out, bus_data_out;
  logic        cpu_read, cpu_write, prc_read, prc_write, bus_read, bus_write;
  logic [1:0]  cpu_bus_status, prc_bus_status, bus_status;
  logic        cpu_sync, cpu_wait, prc_bus_request, prc_bus_ack;
  logic        stolen_clear, sync_timeout;
  logic [15:0] stolen_cycles;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  prc_bus_arbiter #(.RELEASE_GAP(RELEASE_GAP), .SYNC_TIMEOUT(SYNC_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_data_out(cpu_data_out), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_bus_status(cpu_bus_status), .cpu_sync(cpu_sync),
    .cpu_wait(cpu_wait), .prc_bus_request(prc_bus_request), .prc_bus_ack(prc_bus_ack),
    .prc_address(prc_address), .prc_data_out(prc_data_out), .prc_read(prc_read),
    .prc_write(prc_write), .prc_bus_status(prc_bus_status),
    .bus_address(bus_address), .bus_data_out(bus_data_out), .bus_read(bus_read),
    .bus_write(bus_write), .bus_status(bus_status),
    .stolen_clear(stolen_clear), .stolen_cycles(stolen_cycles), .sync_timeout(sync_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the bus, how long the gap still lasts, whether a request waits.
  bit          m_granted, m_pending, m_timeout;
  int          m_gap_left, m_wait;
  logic [15:0] m_stolen;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_granted  <= 1'b0;
      m_pending  <= 1'b0;
      m_timeout  <= 1'b0;
      m_gap_left <= 0;
      m_wait     <= 0;
      m_stolen   <= '0;
    end else begin
      if (stolen_clear)
        m_stolen <= '0;
      else if (m_granted && m_stolen != 16'hFFFF)
        m_stolen <= m_stolen + 16'd1;

      if (m_granted) begin
        if (!prc_bus_request) begin
          m_granted  <= 1'b0;
          m_gap_left <= RELEASE_GAP;
        end
      end else if (m_gap_left > 0) begin
        m_gap_left <= m_gap_left - 1;
      end else if (m_pending) begin
        m_wait <= m_wait + 1;
        if (m_wait + 1 >= SYNC_TIMEOUT) m_timeout <= 1'b1;
        if (!prc_bus_request)
          m_pending <= 1'b0;
        else if (cpu_sync && !cpu_read && !cpu_write) begin
          m_granted <= 1'b1;
          m_pending <= 1'b0;
        end
      end else if (prc_bus_request) begin
        m_pending <= 1'b1;
        m_wait    <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("ack",      {31'd0, prc_bus_ack}, {31'd0, m_granted});
      check("cpu_wait", {31'd0, cpu_wait},    {31'd0, m_granted});
      check("bus_address", {8'd0, bus_address},  {8'd0, m_granted ? prc_address : cpu_address});
      check("bus_data",    {24'd0, bus_data_out}, {24'd0, m_granted ? prc_data_out : cpu_data_out});
      check("bus_rw",      {30'd0, bus_read, bus_write},
            {30'd0, m_granted ? {prc_read, prc_write} : {cpu_read, cpu_write}});
      check("bus_status",  {30'd0, bus_status}, {30'd0, m_granted ? prc_bus_status : cpu_bus_status});
      check("stolen",      {16'd0, stolen_cycles}, {16'd0, m_stolen});
      check("timeout",     {31'd0, sync_timeout}, {31'd0, m_timeout});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int          n;
    logic [15:0] saved;
    reset = 1'b1; prc_bus_request = 1'b0; cpu_sync = 1'b0; stolen_clear = 1'b0;
    cpu_address = 24'h123456; cpu_data_out = 8'h11; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_bus_status = 2'd0;
    prc_address = 24'hABCDEF; prc_data_out = 8'h22; prc_read = 1'b1; prc_write = 1'b0;
    prc_bus_status = 2'd3;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    cmp_en = 1'b1;
    check("reset_ack",    {31'd0, prc_bus_ack}, 32'd0);
    check("reset_wait",   {31'd0, cpu_wait}, 32'd0);
    check("reset_stolen", {16'd0, stolen_cycles}, 32'd0);
    check("reset_addr",   {8'd0, bus_address}, 32'h123456);

    // Grant two edges after request, then hold ten PRC cycles
    cpu_sync = 1'b1; prc_bus_request = 1'b1;
    tick();
    check("t1_ack_edge1", {31'd0, prc_bus_ack}, 32'd0);
    tick();
    check("t1_ack_edge2", {31'd0, prc_bus_ack}, 32'd1);
    check("t1_wait_edge2", {31'd0, cpu_wait}, 32'd1);
    check("t1_bus_addr", {8'd0, bus_address}, 32'hABCDEF);
    repeat (9) tick();
    prc_bus_request = 1'b0;
    tick();
    check("t3_ack_release", {31'd0, prc_bus_ack}, 32'd0);
    check("t3_stolen10", {16'd0, stolen_cycles}, 32'd10);
    prc_bus_request = 1'b1;
    n = 0;
    while (!prc_bus_ack && n < 20) begin tick(); n++; end
    check("t3_regrant_latency", n, RELEASE_GAP + 2);
    prc_bus_request = 1'b0;
    repeat (RELEASE_GAP + 2) tick();

    // Request withdrawn while waiting for sync
    saved = stolen_cycles;
    cpu_sync = 1'b0; prc_bus_request = 1'b1;
    repeat (2) tick();
    prc_bus_request = 1'b0;
    repeat (3) tick();
    check("t4_ack", {31'd0, prc_bus_ack}, 32'd0);
    check("t4_stolen", {16'd0, stolen_cycles}, {16'd0, saved});

    // Sync never arrives for 70 cycles
    prc_bus_request = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (k == 64) check("t2_timeout_before", {31'd0, sync_timeout}, 32'd0);
      if (k == 65) check("t2_timeout_at", {31'd0, sync_timeout}, 32'd1);
    end
    check("t2_no_ack", {31'd0, prc_bus_ack}, 32'd0);
    cpu_sync = 1'b1;
    tick();
    check("t2_ack_after_sync", {31'd0, prc_bus_ack}, 32'd1);

    // Asynchronous reset while granted
    #1 reset = 1'b1;
    #1;
    check("t5_ack", {31'd0, prc_bus_ack}, 32'd0);
    check("t5_wait", {31'd0, cpu_wait}, 32'd0);
    check("t5_addr", {8'd0, bus_address}, 32'h123456);
    check("t5_stolen", {16'd0, stolen_cycles}, 32'd0);
    check("t5_timeout", {31'd0, sync_timeout}, 32'd0);
    tick();
    reset = 1'b0;

    // Saturate the stolen counter then clear it during the grant
    repeat (2) tick();
    check("t6_ack", {31'd0, prc_bus_ack}, 32'd1);
    repeat (65540) tick();
    check("t6_saturated", {16'd0, stolen_cycles}, 32'hFFFF);
    stolen_clear = 1'b1;
    tick();
    check("t6_clear", {16'd0, stolen_cycles}, 32'd0);
    stolen_clear = 1'b0;
    tick();
    check("t6_after_clear", {16'd0, stolen_cycles}, 32'd1);
    prc_bus_request = 1'b0;
    tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) prc_bus_request = ~prc_bus_request;
      cpu_sync       = $urandom_range(1);
      cpu_read       = ($urandom_range(3) == 0);
      cpu_write      = ($urandom_range(3) == 0);
      cpu_address    = 24'($urandom);
      cpu_data_out   = 8'($urandom);
      cpu_bus_status = 2'($urandom);
      prc_address    = 24'($urandom);
      prc_data_out   = 8'($urandom);
      prc_read       = 1'($urandom);
      prc_write      = 1'($urandom);
      prc_bus_status = 2'($urandom);
      stolen_clear   = ($urandom_range(49) == 0);
      reset          = ($urandom_range(199) == 0);
      tick();
    end
    reset = 1'b0;
    tick();
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
